// File: rtl/sea_pkg.sv
// sea_pkg: shared SEA widths, FSM state type and bit/word rotation helpers.
// Helpers operate on the low w bits of an MW-wide vector so any legal W fits.
package sea_pkg;
    localparam int SEA_W = 48;
    localparam int SEA_NR = 16;
    localparam int MW = 384;

    typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;
    typedef logic [MW-1:0] vec_t;

    function automatic vec_t rotl(input vec_t x, input int w, input int s);
        vec_t y;
        y = '0;
        for (int i = 0; i < w; i++) y[(i + s) % w] = x[i];
        return y;
    endfunction

    function automatic vec_t rotr(input vec_t x, input int w, input int s);
        return rotl(x, w, w - s);
    endfunction

    // Word 0 sits in the low byte; wordrot moves every word one position up.
    function automatic vec_t wordrot(input vec_t x, input int w);
        return rotl(x, w, 8);
    endfunction

    function automatic vec_t wordrot_inv(input vec_t x, input int w);
        return rotr(x, w, 8);
    endfunction

    // Within each word triple: word 0 rotates right by one, word 2 left by one.
    function automatic vec_t bitrot(input vec_t x, input int w);
        vec_t y;
        y = x;
        for (int j = 0; j < w / 8; j++)
            for (int b = 0; b < 8; b++)
                if (j % 3 == 0) y[8*j + b] = x[8*j + (b + 1) % 8];
                else if (j % 3 == 2) y[8*j + (b + 1) % 8] = x[8*j + b];
        return y;
    endfunction
endpackage

// File: rtl/sea_round_f.sv
// sea_round_f: combinational SEA round function F(x,k) = bitrot(S(x + k bytewise)).
module sea_round_f
    import sea_pkg::*;
#(
    parameter int W = SEA_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] k,
    output logic [W-1:0] f
);
    logic [W-1:0] s, t;
    genvar j;
    for (j = 0; j < W / 8; j++) begin : g_add
        assign s[8*j +: 8] = x[8*j +: 8] + k[8*j +: 8];
    end
    sea_sbox #(.W(W)) u_sbox (.x(s), .y(t));
    assign f = W'(bitrot(MW'(t), W));
endmodule

// File: rtl/sea_sbox.sv
// sea_sbox: SEA bitsliced 3-bit S-box layer over each triple of 8-bit words.
module sea_sbox #(
    parameter int W = 48
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    localparam int NT = W / 24;
    genvar i;
    for (i = 0; i < NT; i++) begin : g_t
        logic [7:0] a, b, c, a1, b1;
        assign a = x[24*i +: 8];
        assign b = x[24*i + 8 +: 8];
        assign c = x[24*i + 16 +: 8];
        assign a1 = a ^ (b & c);
        assign b1 = b ^ (c & a1);
        assign y[24*i +: 8] = a1;
        assign y[24*i + 8 +: 8] = b1;
        assign y[24*i + 16 +: 8] = c ^ (a1 | b1);
    end
    // Words that do not complete a triple pass through unchanged.
    if (W > 24 * NT) begin : g_p
        assign y[W-1:24*NT] = x[W-1:24*NT];
    end
endmodule

// File: rtl/sea_de_iter.sv
// sea_de_iter: iterative SEA Feistel decryptor, one round per enabled cycle.
// Optional SEA_DE_KEYCACHE_EN keeps K(NR) of the last expanded key to skip KEXP.
module sea_de_iter
    import sea_pkg::*;
#(
    parameter int NR = SEA_NR,
    parameter int W = SEA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] li,
    input  logic [W-1:0] ri,
    input  logic [W-1:0] ki,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] lio,
    output logic [W-1:0] rio
);
    state_t state;
    logic [5:0] cnt;
    logic [W-1:0] key, f, kf, kb;
`ifdef SEA_DE_KEYCACHE_EN
    logic [W-1:0] ck_ki, ck_k;
    logic ck_v;
`endif

    sea_round_f #(.W(W)) u_f (.x(lio), .k(key), .f(f));

    // cnt always holds the index of the key currently in the key register.
    assign kf = W'(rotl(MW'(key), W, 8)) ^ W'(cnt);
    assign kb = W'(rotr(MW'(key ^ W'(cnt - 6'd1)), W, 8));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            key <= '0;
            lio <= '0;
            rio <= '0;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
`ifdef SEA_DE_KEYCACHE_EN
            ck_ki <= '0;
            ck_k <= '0;
            ck_v <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lio <= li;
                        rio <= ri;
                        in_ready <= 1'b0;
`ifdef SEA_DE_KEYCACHE_EN
                        if (ck_v && ki == ck_ki) begin
                            key <= ck_k;
                            cnt <= 6'(NR);
                            state <= DEC;
                        end else begin
                            key <= ki;
                            cnt <= 6'd1;
                            state <= KEXP;
                            ck_ki <= ki;
                            ck_v <= 1'b0;
                        end
`else
                        key <= ki;
                        cnt <= 6'd1;
                        state <= KEXP;
`endif
                    end
                end
                KEXP: begin
                    key <= kf;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(NR - 1)) begin
                        state <= DEC;
`ifdef SEA_DE_KEYCACHE_EN
                        ck_k <= kf;
                        ck_v <= 1'b1;
`endif
                    end
                end
                DEC: begin
                    lio <= W'(wordrot_inv(MW'(rio ^ f), W));
                    rio <= lio;
                    // Stop at round 1 without stepping so the counter never reaches 0.
                    if (cnt == 6'd1) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        key <= kb;
                        cnt <= cnt - 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sea_de_iter.sv
// tb_sea_de_iter: scoreboard bench; jobs are encrypted by a reference SEA model,
// decrypted by the DUT and compared against the original plaintext and latency.
module tb_sea_de_iter;
    localparam int W = 48;
    localparam int NR = 16;
    localparam logic [2:0] SB [8] = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd3, 3'd1, 3'd2};

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int t;
        int lat;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [W-1:0] li = '0, ri = '0, ki = '0, lio, rio;
    int cyc = 0, errs = 0, checks = 0, n_acc = 0, n_out = 0;
    bit rand_or = 1'b0, cv = 1'b0;
    logic [W-1:0] cki = '0;
    exp_t q[$];

    sea_de_iter dut (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .li(li), .ri(ri), .ki(ki), .out_valid(out_valid), .out_ready(out_ready),
        .lio(lio), .rio(rio)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
    endtask

    // Reference round function from the SEA definition: byte add, S-box table, bit rotations.
    function automatic logic [W-1:0] model_f(input logic [W-1:0] x, input logic [W-1:0] k);
        logic [7:0] y [W/8];
        logic [W-1:0] o;
        for (int j = 0; j < W / 8; j++) y[j] = x[8*j +: 8] + k[8*j +: 8];
        for (int i = 0; i + 2 < W / 8; i += 3)
            for (int b = 0; b < 8; b++)
                {y[i+2][b], y[i+1][b], y[i][b]} = SB[{y[i+2][b], y[i+1][b], y[i][b]}];
        for (int i = 0; i + 2 < W / 8; i += 3) begin
            y[i] = {y[i][0], y[i][7:1]};
            y[i+2] = {y[i+2][6:0], y[i+2][7]};
        end
        for (int j = 0; j < W / 8; j++) o[8*j +: 8] = y[j];
        return o;
    endfunction

    function automatic void encrypt(input logic [W-1:0] pl, input logic [W-1:0] pr,
                                    input logic [W-1:0] k,
                                    output logic [W-1:0] cl, output logic [W-1:0] cr);
        logic [W-1:0] l, r, kk, t;
        l = pl;
        r = pr;
        kk = k;
        for (int i = 1; i <= NR; i++) begin
            t = r;
            r = {l[W-9:0], l[W-1:W-8]} ^ model_f(r, kk);
            l = t;
            kk = {kk[W-9:0], kk[W-1:W-8]} ^ W'(i);
        end
        cl = l;
        cr = r;
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    // Offers one job from a negedge, returns right after the accepting posedge.
    task automatic send(input logic [W-1:0] pl, input logic [W-1:0] pr,
                        input logic [W-1:0] k, input int extra);
        logic [W-1:0] cl, cr;
        int lat, g;
        @(negedge clk);
        encrypt(pl, pr, k, cl, cr);
        li = cl;
        ri = cr;
        ki = k;
        in_valid = 1'b1;
        g = 0;
        while (!(in_ready && ena) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            timeout("accept");
            return;
        end
`ifdef SEA_DE_KEYCACHE_EN
        lat = (cv && k == cki) ? NR + 1 : 2 * NR;
        cki = k;
        cv = 1'b1;
`else
        lat = 2 * NR;
`endif
        q.push_back('{pl, pr, cyc + 1, lat + extra});
        n_acc++;
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((q.size() != 0 || !in_ready) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) timeout("drain");
    endtask

    initial forever begin
        @(negedge clk);
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops one expectation per rising out_valid, rechecks data on release.
    initial begin
        exp_t cur;
        bit pov, have;
        pov = 1'b0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && !pov) begin
                n_out++;
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL spurious_output: lio=%h rio=%h with no job pending", lio, rio);
                end else begin
                    cur = q.pop_front();
                    have = 1'b1;
                    check("lio", lio, cur.l);
                    check("rio", rio, cur.r);
                    check("latency", W'(cyc - cur.t + 1), W'(cur.lat));
                end
            end
            if (out_valid) check("in_ready_in_done", W'(in_ready), '0);
            if (out_valid && out_ready && ena && have) begin
                check("lio_release", lio, cur.l);
                check("rio_release", rio, cur.r);
                have = 1'b0;
            end
            pov = out_valid;
        end
    end

    initial begin
        logic [W-1:0] pl, pr, k1;
        int g;
        repeat (2) @(negedge clk);
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), '0);
        check("reset_lio", lio, '0);
        check("reset_rio", rio, '0);
        rst = 1'b0;

        send(48'h0123456789AB, 48'hFEDCBA987654, 48'h0F1E2D3C4B5A, 0);
        @(negedge clk) in_valid = 1'b0;
        wait_idle();

        // Backpressure: result must hold while out_ready stays low.
        out_ready = 1'b0;
        pl = rnd();
        pr = rnd();
        send(pl, pr, rnd(), 0);
        @(negedge clk) in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) timeout("out_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", W'(out_valid), W'(1));
            check("hold_lio", lio, pl);
            check("hold_rio", rio, pr);
            check("hold_in_ready", W'(in_ready), '0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", W'(in_ready), W'(1));
        check("release_out_valid", W'(out_valid), '0);

        // Enable toggling 1,0,1,0 during key expansion adds exactly two cycles.
        send(rnd(), rnd(), rnd(), 2);
        @(negedge clk) in_valid = 1'b0;
        ena = 1'b1;
        @(negedge clk) ena = 1'b0;
        @(negedge clk) ena = 1'b1;
        @(negedge clk) ena = 1'b0;
        @(negedge clk) ena = 1'b1;
        wait_idle();

        // Asynchronous reset in the middle of decryption discards the job.
        send(rnd(), rnd(), rnd(), 0);
        @(negedge clk) in_valid = 1'b0;
        repeat (NR - 1 + 6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_lio", lio, '0);
        check("async_rst_rio", rio, '0);
        check("async_rst_out_valid", W'(out_valid), '0);
        check("async_rst_in_ready", W'(in_ready), W'(1));
        q.delete();
        n_acc--;
        cv = 1'b0;
        @(negedge clk) rst = 1'b0;
        send(48'h0123456789AB, 48'hFEDCBA987654, 48'h0F1E2D3C4B5A, 0);
        @(negedge clk) in_valid = 1'b0;
        wait_idle();

        // Same key twice, then a new key (cache hit/miss when the cache is built in).
        k1 = 48'hA5A5_5A5A_C3C3;
        send(rnd(), rnd(), k1, 0);
        @(negedge clk) in_valid = 1'b0;
        wait_idle();
        send(rnd(), rnd(), k1, 0);
        @(negedge clk) in_valid = 1'b0;
        wait_idle();
        send(rnd(), rnd(), ~k1, 0);
        @(negedge clk) in_valid = 1'b0;
        wait_idle();

        // Random sweep with in_valid held high and random backpressure.
        rand_or = 1'b1;
        for (int i = 0; i < 1000; i++) send(rnd(), rnd(), rnd(), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rand_or = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        check("output_count", W'(n_out), W'(n_acc));
        check("queue_empty", W'(q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sea_de_iter.md
SEA_DE_ITER -- requirements
Module: sea_de_iter

Interface
REQ-001 Parameter NR, default 16: number of Feistel rounds, legal range 2..63.
REQ-002 Parameter W, default 48: half-block and key width; a multiple of 8 (W/8 byte words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ena  input  1  global enable; low freezes all state and outputs.
REQ-006 in_valid  input  1  ciphertext/key offer.
REQ-007 in_ready  output  1  block accepts a job.
REQ-008 li, ri  input  W each  ciphertext left/right halves.
REQ-009 ki  input  W  master key, identical to the key given to the encryptor.
REQ-010 out_valid  output  1  plaintext available.
REQ-011 out_ready  input  1  downstream accepts plaintext.
REQ-012 lio, rio  output  W each  recovered plaintext halves.

Function
REQ-013 Round function SHALL be F(x,k) = bitrot(S(x ⊞ k)): ⊞ is per-byte add mod 256; S is the shared SEA bitsliced S-box layer; bitrot is the encryptor's per-word bit rotation.
REQ-014 Key step SHALL be K(i+1) = rotl(K(i),8) ^ i (i zero-extended to W); K(1) = ki; inverse K(i) = rotr(K(i+1) ^ i, 8).
REQ-015 Each decrypt round i = NR..1 SHALL compute R' = L and L' = wordrot_inv(R ^ F(L, K(i))), the exact inverse of the sea_en round.
REQ-016 FSM states SHALL be IDLE, KEXP, DEC, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, latch li/ri/ki and move to KEXP.
REQ-018 KEXP SHALL apply the forward key step NR-1 times, one per enabled cycle, to reach K(NR), then move to DEC.
REQ-019 DEC SHALL perform one round per enabled cycle, stepping the key backward after each round; after round 1 it moves to DONE.
REQ-020 DONE: out_valid=1 with lio/rio stable until out_ready, then return to IDLE; in_ready stays 0 in this cycle.
REQ-021 Latency SHALL be: acceptance at edge t gives out_valid=1 after edge t+2*NR-1 (32 cycles at NR=16), excluding cycles with ena low.
REQ-022 in_ready SHALL be 0 in KEXP, DEC and DONE; in_valid in those states is ignored.
REQ-023 The round counter SHALL be 6 bits and SHALL never wrap; a count of 0 is illegal.
REQ-024 ena low SHALL hold state, counter, key and data; handshake outputs keep their values, but no transfer completes.

Reset
REQ-025 rst high SHALL force IDLE immediately, regardless of clk or ena, including mid-KEXP or mid-DEC; the in-flight job is discarded.
REQ-026 Reset values SHALL be: in_ready=1, out_valid=0, lio=0, rio=0, counter=0, key and data registers 0.

Configuration
REQ-027 Macro SEA_DE_KEYCACHE_EN, when defined, SHALL retain K(NR) and its ki after each KEXP.
REQ-028 With the macro defined, an accepted ki equal to the cached ki (cache valid) SHALL skip KEXP and enter DEC directly, giving latency NR+1.
REQ-029 Reset SHALL invalidate the cache.
REQ-030 Without the macro, KEXP SHALL always run and no cache registers SHALL exist.

Structure
REQ-031 Shared package sea_pkg SHALL hold the W and NR defaults, the state enum, and the wordrot/bitrot/rotl/rotr functions.
REQ-032 One sub-module, sea_round_f, SHALL implement F combinationally, reusing the existing sbox module.

Verification
REQ-033 NR=16: plaintext 0123456789AB/FEDCBA987654 with ki 0F1E2D3C4B5A, encrypted by the sea_en model and then decrypted -> lio/rio equal the plaintext; out_valid is 1 exactly 32 cycles after acceptance.
REQ-034 out_ready held low for 10 cycles in DONE -> out_valid and lio/rio stay constant, in_ready=0; one cycle after out_ready=1, in_ready=1.
REQ-035 rst pulsed at DEC round 7 -> outputs go to 0 asynchronously, state is IDLE; a following job decrypts correctly.
REQ-036 ena toggled 1010 during KEXP -> result correct, latency extended by exactly 2 cycles.
REQ-037 With SEA_DE_KEYCACHE_EN: two back-to-back jobs with the same ki -> second latency 17; a different ki -> 32.
REQ-038 Random sweep: 1000 random li/ri/ki pairs round-trip against the model; in_valid held high throughout never causes a double acceptance.
